mem_arbiter_rr: RTL and testbench

Round-robin arbiter that shares one memory port among `p_num_clients` requesters, such as fetch and one or more load/store units, in the L7 core. It forwards one granted request per cycle combinationally to the memory port. It records the winning client index in an in-flight ID FIFO and steers each in-order memory response back to the client that issued it. The block owns all fairness and ordering state; it does not modify message contents.

---
 rtl/mem_arbiter_rr_if.sv | 31 +++
 rtl/mem_arbiter_rr.sv | 136 +++++++++++++
 tb/tb_mem_arbiter_rr.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : MemIntf
// Description : Valid/ready memory request/response channel pair.
// Revision    : 1.0 - initial release
// ============================================================================
interface MemIntf #(
    parameter int p_opaq_bits = 8
);
    // Message layout: {type[2:0], opaque, addr[31:0], len[1:0], data[31:0]}
    localparam int c_req_bits  = 3 + p_opaq_bits + 32 + 2 + 32;
    localparam int c_resp_bits = 3 + p_opaq_bits + 2 + 32;

    logic                   req_val;
    logic                   req_rdy;
    logic [c_req_bits-1:0]  req_msg;
    logic                   resp_val;
    logic                   resp_rdy;
    logic [c_resp_bits-1:0] resp_msg;

    modport server (
        input  req_val, req_msg, resp_rdy,
        output req_rdy, resp_val, resp_msg
    );

    modport client (
        output req_val, req_msg, resp_rdy,
        input  req_rdy, resp_val, resp_msg
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_rr
// Description : Round-robin arbiter sharing one memory port; an in-flight ID
//               FIFO steers in-order responses back to the issuing client.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr #(
    parameter int p_num_clients   = 2,
    parameter int p_opaq_bits     = 8,
    parameter int p_num_in_flight = 8
) (
    input  logic   clk,
    input  logic   rst,
    MemIntf.server client [p_num_clients],
    MemIntf.client mem
);
    localparam int c_idx_bits = $clog2(p_num_clients);
    localparam int c_ptr_bits = (p_num_in_flight > 1) ? $clog2(p_num_in_flight) : 1;
    localparam int c_cnt_bits = $clog2(p_num_in_flight + 1);
    localparam int c_req_bits = 3 + p_opaq_bits + 32 + 2 + 32;

    localparam logic [c_idx_bits-1:0] c_last_client = c_idx_bits'(p_num_clients - 1);
    localparam logic [c_ptr_bits-1:0] c_last_slot   = c_ptr_bits'(p_num_in_flight - 1);
    localparam logic [c_cnt_bits-1:0] c_depth       = c_cnt_bits'(p_num_in_flight);
    localparam logic [c_idx_bits:0]   c_num_ext     = (c_idx_bits + 1)'(p_num_clients);

    logic [c_idx_bits-1:0] rr_ptr_q, rr_ptr_d;
    logic [c_ptr_bits-1:0] head_q, head_d;
    logic [c_ptr_bits-1:0] tail_q, tail_d;
    logic [c_cnt_bits-1:0] count_q, count_d;
    logic [c_idx_bits-1:0] fifo_q [p_num_in_flight];

    logic [p_num_clients-1:0] w_req_val;
    logic [p_num_clients-1:0] w_resp_rdy;
    logic [c_req_bits-1:0]    w_req_msg [p_num_clients];
    logic [c_idx_bits-1:0]    w_grant;
    logic [c_idx_bits-1:0]    w_head_id;
    logic [c_idx_bits:0]      w_scan;
    logic                     w_any_val;
    logic                     w_active;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic                     w_push;
    logic                     w_pop;

    // Outputs are forced low while reset is held, independent of inputs.
    assign w_active     = !rst;
    assign w_fifo_full  = (count_q == c_depth);
    assign w_fifo_empty = (count_q == '0);
    assign w_head_id    = fifo_q[head_q];

    generate
        for (genvar i = 0; i < p_num_clients; i++) begin : g_client
            assign w_req_val[i]      = client[i].req_val;
            assign w_req_msg[i]      = client[i].req_msg;
            assign w_resp_rdy[i]     = client[i].resp_rdy;
            assign client[i].req_rdy = w_active && (w_grant == c_idx_bits'(i))
                                       && mem.req_rdy && !w_fifo_full;
            assign client[i].resp_val = w_active && (w_head_id == c_idx_bits'(i))
                                        && mem.resp_val && !w_fifo_empty;
            assign client[i].resp_msg = mem.resp_msg;
        end
    endgenerate

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        w_grant   = '0;
        w_any_val = 1'b0;
        w_scan    = '0;
        for (int k = 0; k < p_num_clients; k++) begin
            w_scan = {1'b0, rr_ptr_q} + (c_idx_bits + 1)'(k);
            if (w_scan >= c_num_ext) begin
                w_scan = w_scan - c_num_ext;
            end
            if (!w_any_val && w_req_val[w_scan[c_idx_bits-1:0]]) begin
                w_any_val = 1'b1;
                w_grant   = w_scan[c_idx_bits-1:0];
            end
        end
    end

    assign mem.req_val  = w_active && w_any_val && !w_fifo_full;
    assign mem.req_msg  = w_req_msg[w_grant];
    assign mem.resp_rdy = w_active && w_resp_rdy[w_head_id] && !w_fifo_empty;

    assign w_push = mem.req_val && mem.req_rdy;
    assign w_pop  = mem.resp_val && mem.resp_rdy;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (w_push) begin
            rr_ptr_d = (w_grant == c_last_client) ? '0 : w_grant + 1'b1;
            tail_d   = (tail_q == c_last_slot) ? '0 : tail_q + 1'b1;
        end
        if (w_pop) begin
            head_d = (head_q == c_last_slot) ? '0 : head_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    // ID storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[tail_q] <= w_grant;
        end
    end

`ifndef SYNTHESIS
    a_no_resp_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(mem.resp_val && w_fifo_empty));
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter_rr
// Description : Directed self-checking bench for mem_arbiter_rr (2 clients,
//               4-deep ID FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_rr;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    MemIntf #(.p_opaq_bits(8)) cif [2] ();
    MemIntf #(.p_opaq_bits(8)) mif ();

    mem_arbiter_rr #(
        .p_num_clients   (2),
        .p_opaq_bits     (8),
        .p_num_in_flight (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .client (cif),
        .mem    (mif)
    );

    logic [1:0] w_rdy;
    logic [1:0] w_rv;
    assign w_rdy = {cif[1].req_rdy, cif[0].req_rdy};
    assign w_rv  = {cif[1].resp_val, cif[0].resp_val};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [76:0] mk_req(input logic [31:0] addr);
        return {3'd0, 8'h5A, addr, 2'd0, 32'h0};
    endfunction

    function automatic logic [44:0] mk_resp(input logic [31:0] data);
        return {3'd0, 8'h00, 2'd0, data};
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cif[0].req_val = 1'b1;
        cif[1].req_val = 1'b1;
        mif.req_rdy    = 1'b1;
        #1;
        n_checks++;
        if ({mif.req_val, mif.resp_rdy, w_rdy, w_rv} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 000000", {mif.req_val, mif.resp_rdy, w_rdy, w_rv});
        end
        n_checks++;
        if ({dut.rr_ptr_q, dut.count_q, dut.head_q, dut.tail_q} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 00000000", {dut.rr_ptr_q, dut.count_q, dut.head_q, dut.tail_q});
        end
        tick;
        tick;
        rst = 1'b0;
        cif[0].req_val = 1'b0;
        cif[1].req_val = 1'b0;
    endtask

    task automatic test_round_robin;
        logic [1:0]  exp_rdy;
        logic [76:0] exp_msg;
        for (int c = 0; c < 6; c++) begin
            cif[0].req_val = (c < 4);
            cif[1].req_val = (c < 4);
            cif[0].req_msg = mk_req(32'h1000 + c);
            cif[1].req_msg = mk_req(32'h2000 + c);
            mif.resp_val   = (c >= 2);
            mif.resp_msg   = mk_resp(32'hA0 + c);
            #1;
            if (c < 4) begin
                exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
                exp_msg = (c % 2 == 0) ? mk_req(32'h1000 + c) : mk_req(32'h2000 + c);
                n_checks++;
                if (w_rdy !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL rr_grant c%0d: got %b want %b", c, w_rdy, exp_rdy);
                end
                n_checks++;
                if (mif.req_msg !== exp_msg) begin
                    n_fail++;
                    $display("FAIL rr_req_msg c%0d: got %h want %h", c, mif.req_msg, exp_msg);
                end
            end
            if (c >= 2) begin
                exp_rdy = ((c - 2) % 2 == 0) ? 2'b01 : 2'b10;
                n_checks++;
                if ({mif.resp_rdy, w_rv} !== {1'b1, exp_rdy}) begin
                    n_fail++;
                    $display("FAIL rr_resp_route c%0d: got %b want %b", c, {mif.resp_rdy, w_rv}, {1'b1, exp_rdy});
                end
                n_checks++;
                if (cif[0].resp_msg !== mk_resp(32'hA0 + c) || cif[1].resp_msg !== mk_resp(32'hA0 + c)) begin
                    n_fail++;
                    $display("FAIL rr_resp_data c%0d: got %h/%h want %h", c, cif[0].resp_msg, cif[1].resp_msg, mk_resp(32'hA0 + c));
                end
            end
            tick;
        end
        cif[0].req_val = 1'b0;
        cif[1].req_val = 1'b0;
        mif.resp_val   = 1'b0;
        n_checks++;
        if ({dut.rr_ptr_q, dut.count_q} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rr_end_state: got %b want 0000", {dut.rr_ptr_q, dut.count_q});
        end
    endtask

    task automatic test_single_client;
        for (int c = 0; c < 3; c++) begin
            cif[1].req_val = 1'b1;
            cif[1].req_msg = mk_req(32'h100 + 4 * c);
            #1;
            n_checks++;
            if (w_rdy !== 2'b10 || mif.req_msg !== mk_req(32'h100 + 4 * c)) begin
                n_fail++;
                $display("FAIL single_grant c%0d: got rdy=%b msg=%h want rdy=10 msg=%h", c, w_rdy, mif.req_msg, mk_req(32'h100 + 4 * c));
            end
            tick;
        end
        cif[1].req_val = 1'b0;
        n_checks++;
        if ({dut.rr_ptr_q, dut.count_q} !== 4'b0011) begin
            n_fail++;
            $display("FAIL single_state: got %b want 0011", {dut.rr_ptr_q, dut.count_q});
        end
        for (int c = 0; c < 3; c++) begin
            mif.resp_val = 1'b1;
            mif.resp_msg = mk_resp(32'hD0 + c);
            #1;
            n_checks++;
            if ({mif.req_val, w_rv} !== 3'b010) begin
                n_fail++;
                $display("FAIL single_resp c%0d: got %b want 010", c, {mif.req_val, w_rv});
            end
            tick;
        end
        mif.resp_val = 1'b0;
    endtask

    task automatic test_fifo_full;
        cif[0].req_val = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cif[0].req_msg = mk_req(32'h300 + c);
            #1;
            n_checks++;
            if (w_rdy !== 2'b01) begin
                n_fail++;
                $display("FAIL fill_grant c%0d: got %b want 01", c, w_rdy);
            end
            tick;
        end
        #1;
        n_checks++;
        if ({mif.req_val, w_rdy, dut.count_q} !== 6'b000100) begin
            n_fail++;
            $display("FAIL full_block: got %b want 000100", {mif.req_val, w_rdy, dut.count_q});
        end
        // Full with a response and a pending request: pop only
        mif.resp_val = 1'b1;
        mif.resp_msg = mk_resp(32'hB0);
        #1;
        n_checks++;
        if ({mif.req_val, w_rdy, mif.resp_rdy, w_rv} !== 6'b000101) begin
            n_fail++;
            $display("FAIL full_pop_cycle: got %b want 000101", {mif.req_val, w_rdy, mif.resp_rdy, w_rv});
        end
        tick;
        mif.resp_val = 1'b0;
        n_checks++;
        if (dut.count_q !== 3'd3) begin
            n_fail++;
            $display("FAIL full_pop_count: got %0d want 3", dut.count_q);
        end
        #1;
        n_checks++;
        if ({mif.req_val, w_rdy} !== 3'b101) begin
            n_fail++;
            $display("FAIL release_one: got %b want 101", {mif.req_val, w_rdy});
        end
        tick;
        n_checks++;
        if ({mif.req_val, w_rdy, dut.count_q} !== 6'b000100) begin
            n_fail++;
            $display("FAIL refull: got %b want 000100", {mif.req_val, w_rdy, dut.count_q});
        end
        cif[0].req_val = 1'b0;
        mif.resp_val   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
        end
        mif.resp_val = 1'b0;
        n_checks++;
        if ({dut.rr_ptr_q, dut.count_q} !== 4'b1000) begin
            n_fail++;
            $display("FAIL full_drain: got %b want 1000", {dut.rr_ptr_q, dut.count_q});
        end
    endtask

    task automatic test_resp_backpressure;
        cif[0].req_val = 1'b1;
        #1;
        n_checks++;
        if (w_rdy !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_grant0: got %b want 01", w_rdy);
        end
        tick;
        cif[0].req_val = 1'b0;
        cif[1].req_val = 1'b1;
        #1;
        n_checks++;
        if (w_rdy !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_grant1: got %b want 10", w_rdy);
        end
        tick;
        cif[1].req_val   = 1'b0;
        cif[0].resp_rdy  = 1'b0;
        mif.resp_val     = 1'b1;
        mif.resp_msg     = mk_resp(32'hC0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if ({mif.resp_rdy, w_rv} !== 3'b001) begin
                n_fail++;
                $display("FAIL bp_hold c%0d: got %b want 001", c, {mif.resp_rdy, w_rv});
            end
            tick;
        end
        n_checks++;
        if (dut.count_q !== 3'd2) begin
            n_fail++;
            $display("FAIL bp_count: got %0d want 2", dut.count_q);
        end
        cif[0].resp_rdy = 1'b1;
        #1;
        n_checks++;
        if ({mif.resp_rdy, w_rv} !== 3'b101) begin
            n_fail++;
            $display("FAIL bp_release: got %b want 101", {mif.resp_rdy, w_rv});
        end
        tick;
        mif.resp_msg = mk_resp(32'hC1);
        #1;
        n_checks++;
        if ({mif.resp_rdy, w_rv} !== 3'b110) begin
            n_fail++;
            $display("FAIL bp_second: got %b want 110", {mif.resp_rdy, w_rv});
        end
        tick;
        mif.resp_val = 1'b0;
        n_checks++;
        if (dut.count_q !== 3'd0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d want 0", dut.count_q);
        end
    endtask

    task automatic test_reset_mid;
        cif[0].req_val = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
        end
        cif[1].req_val = 1'b1;
        mif.resp_val   = 1'b1;
        #1;
        n_checks++;
        if ({mif.req_val, dut.rr_ptr_q, dut.count_q} !== 5'b11011) begin
            n_fail++;
            $display("FAIL pre_reset: got %b want 11011", {mif.req_val, dut.rr_ptr_q, dut.count_q});
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({mif.req_val, mif.resp_rdy, w_rdy, w_rv, dut.count_q} !== 9'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b want 000000000", {mif.req_val, mif.resp_rdy, w_rdy, w_rv, dut.count_q});
        end
        mif.resp_val = 1'b0;
        tick;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({dut.rr_ptr_q, dut.count_q, w_rdy} !== 6'b000001) begin
            n_fail++;
            $display("FAIL post_reset: got %b want 000001", {dut.rr_ptr_q, dut.count_q, w_rdy});
        end
        tick;
        cif[0].req_val = 1'b0;
        cif[1].req_val = 1'b0;
        n_checks++;
        if ({dut.rr_ptr_q, dut.count_q} !== 4'b1001) begin
            n_fail++;
            $display("FAIL post_reset_push: got %b want 1001", {dut.rr_ptr_q, dut.count_q});
        end
        mif.resp_val = 1'b1;
        #1;
        n_checks++;
        if (w_rv !== 2'b01) begin
            n_fail++;
            $display("FAIL post_reset_resp: got %b want 01", w_rv);
        end
        tick;
        mif.resp_val = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        for (int i = 0; i < 1; i++) begin
            cif[0].req_val  = 1'b0;
            cif[0].req_msg  = '0;
            cif[0].resp_rdy = 1'b1;
            cif[1].req_val  = 1'b0;
            cif[1].req_msg  = '0;
            cif[1].resp_rdy = 1'b1;
        end
        mif.req_rdy  = 1'b1;
        mif.resp_val = 1'b0;
        mif.resp_msg = '0;
        test_reset;
        test_round_robin;
        test_single_client;
        test_fifo_full;
        test_resp_backpressure;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
